// File: rtl/text_buffer_writer.sv
// Character-cell frame buffer for the VGA text renderer: a byte stream writes glyphs at a cursor,
// and the renderer reads cells by (column, row) with one cycle of latency.
module text_buffer_writer #(
    parameter int         COLS         = 40,
    parameter int         ROWS         = 15,
    parameter logic [7:0] GLYPH_OFFSET = 8'd43,
    parameter logic [7:0] BLANK_GLYPH  = 8'd0
) (
    input  logic       master_clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    input  logic [5:0] rd_col,
    input  logic [3:0] rd_row,
    output logic [7:0] rd_glyph,
    output logic [5:0] cursor_col,
    output logic [3:0] cursor_row,
    output logic       busy
);

    localparam int         CELLS     = COLS * ROWS;
    localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
    localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
    localparam logic [9:0] LAST_CELL = 10'(CELLS - 1);
    localparam logic [9:0] ROW_PITCH = 10'(COLS);

    localparam logic [7:0] CH_SPACE     = 8'h20;
    localparam logic [7:0] CH_NEWLINE   = 8'h0A;
    localparam logic [7:0] CH_BACKSPACE = 8'h08;
    localparam logic [7:0] CH_FORMFEED  = 8'h0C;
    localparam logic [7:0] CH_PRINT_LO  = 8'h2B;
    localparam logic [7:0] CH_PRINT_HI  = 8'h7A;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t     state, state_nx;
    logic [9:0] sweep_addr, sweep_nx;
    logic [5:0] col_nx, adv_col;
    logic [3:0] row_nx, adv_row;
    logic       we;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [9:0] cur_addr;
    logic [9:0] rd_addr;
    logic       rd_in_range;

    logic [7:0] mem [CELLS];

    assign in_ready = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign cur_addr = 10'(cursor_row) * ROW_PITCH + 10'(cursor_col);

    // Cursor position after a printing character: wrap to the next row, and from the last cell back to (0,0).
    always_comb begin
        adv_col = cursor_col + 6'd1;
        adv_row = cursor_row;
        if (cursor_col == LAST_COL) begin
            adv_col = '0;
            adv_row = (cursor_row == LAST_ROW) ? '0 : cursor_row + 4'd1;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nx = state;
        sweep_nx = sweep_addr;
        col_nx   = cursor_col;
        row_nx   = cursor_row;
        we       = 1'b0;
        wr_addr  = cur_addr;
        wr_data  = BLANK_GLYPH;

        unique case (state)
            CLEAR: begin
                we      = 1'b1;
                wr_addr = sweep_addr;
                if (sweep_addr == LAST_CELL) begin
                    state_nx = IDLE;
                    sweep_nx = '0;
                    col_nx   = '0;
                    row_nx   = '0;
                end else begin
                    sweep_nx = sweep_addr + 10'd1;
                end
            end

            IDLE: begin
                if (in_valid) begin
                    if (in_byte >= CH_PRINT_LO && in_byte <= CH_PRINT_HI) begin
                        we      = 1'b1;
                        wr_data = in_byte - GLYPH_OFFSET;
                        col_nx  = adv_col;
                        row_nx  = adv_row;
                    end else begin
                        unique case (in_byte)
                            CH_SPACE: begin
                                we     = 1'b1;
                                col_nx = adv_col;
                                row_nx = adv_row;
                            end
                            CH_NEWLINE: begin
                                col_nx = '0;
                                row_nx = (cursor_row == LAST_ROW) ? '0 : cursor_row + 4'd1;
                            end
                            CH_BACKSPACE: begin
                                if (cursor_col != '0) col_nx = cursor_col - 6'd1;
                            end
                            CH_FORMFEED: begin
                                state_nx = CLEAR;
                                sweep_nx = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            sweep_addr <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            state      <= state_nx;
            sweep_addr <= sweep_nx;
            cursor_col <= col_nx;
            cursor_row <= row_nx;
        end
    end

    // NOTE: the cell array has no reset so it maps onto block RAM; the clear sweep initialises it instead.
    always_ff @(posedge master_clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_in_range = (rd_col <= LAST_COL) && (rd_row <= LAST_ROW);
    assign rd_addr     = 10'(rd_row) * ROW_PITCH + 10'(rd_col);

    // Reading the array before the write above lands gives read-before-write on a shared address.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_glyph <= BLANK_GLYPH;
        end else begin
            rd_glyph <= rd_in_range ? mem[rd_addr] : BLANK_GLYPH;
        end
    end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Character-cell frame buffer that sits directly upstream of the VGA text renderer.
- Holds 40 columns x 15 rows of 8-bit glyph indices in a 600-entry dual-port RAM.
- Write side: a byte stream of ASCII characters and control codes, placed at an internal cursor.
- Read side: the renderer addresses cells by (column, row) and receives the glyph index one cycle later.

Parameters:
COLS, 40, character columns per row
ROWS, 15, character rows per screen
GLYPH_OFFSET, 43, subtracted from printable ASCII to form the glyph index
BLANK_GLYPH, 0, glyph index written by clear and returned for out-of-range reads

Ports:
master_clk  in  1  system clock; the write side and read side both run on it
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  in_byte carries a character
in_byte  in  8  ASCII character or control code
in_ready  out  1  block can accept in_byte this cycle
rd_col  in  6  renderer cell column
rd_row  in  4  renderer cell row
rd_glyph  out  8  glyph index for the (rd_col, rd_row) presented one cycle earlier
cursor_col  out  6  current cursor column
cursor_row  out  4  current cursor row
busy  out  1  clear sweep in progress

Behaviour:
- Clock and reset: one clock, master_clk. reset_n is asynchronous, active-low.
- Reset values:
  - cursor_col=0, cursor_row=0.
  - rd_glyph=BLANK_GLYPH.
  - State=CLEAR with sweep address 0, so busy=1 and in_ready=0.
  - RAM contents are undefined until the sweep completes.
- Cell address = row*COLS + col, 10 bits wide, range 0..599.
- FSM states: IDLE, CLEAR.
  - in_ready = (state==IDLE); busy = (state==CLEAR).
  - A byte is accepted on any rising edge where in_valid & in_ready are both 1.
- CLEAR:
  - Writes BLANK_GLYPH to one address per cycle, ascending 0..599.
  - On the edge that writes address 599, goes to IDLE and sets the cursor to (0,0).
  - Total duration is exactly COLS*ROWS = 600 cycles.
  - in_valid is ignored throughout; nothing is queued.
- IDLE, accepted byte b, by range:
  - b in 0x2B..0x7A (printable): write b-GLYPH_OFFSET at the cursor address on the accepting edge, then advance the cursor.
  - b = 0x20 (space): write BLANK_GLYPH at the cursor, then advance.
  - b = 0x0A (newline): no write; col=0, row=row+1, and row 14 wraps to 0.
  - b = 0x08 (backspace): no write; if col>0 then col=col-1, otherwise no change. It does not cross rows.
  - b = 0x0C (form feed): enter CLEAR with sweep address 0; in_ready drops on the next cycle.
  - Any other value: consumed, with no write and no cursor change.
- Cursor advance: col=col+1.
  - At col 39: col=0, row=row+1.
  - At row 14, col 39: wraps to (0,0). There is no scrolling.
- Read port:
  - rd_glyph is registered, with 1-cycle latency.
  - If rd_col>=COLS or rd_row>=ROWS, the next cycle returns BLANK_GLYPH.
  - Read and write to the same address on the same edge returns the old contents (read-before-write).
  - The read port operates during CLEAR; cells not yet swept return undefined data.
- Reset asserted mid-operation, including mid-CLEAR: the sweep restarts at address 0 and the cursor returns to (0,0).
- cursor_col and cursor_row update on the same edge as the accept and are visible the next cycle.

Test Plan:
- Release reset, hold in_valid=1 -> in_ready=0 and busy=1 for exactly 600 cycles, then in_ready=1. Every cell (0..39, 0..14) then reads 0 with 1-cycle latency.
- After clear, send 'A' (0x41) then '9' (0x39) -> cell (0,0) reads 22, cell (1,0) reads 14, cursor=(2,0).
- Send 39 'a' bytes then 'b' -> cell (38,0)=54, cell (39,0)=55, cursor=(0,1). Then send 0x0A fourteen times -> the cursor row wraps from 14 back to 0.
- Cursor at (0,3): send 0x08 -> cursor unchanged. Send 'x', 0x08, 'y' -> cell (0,3)=78, cursor=(1,3).
- Read rd_col=45, rd_row=2, then rd_row=15 -> rd_glyph=0 in both following cycles. Write 'Q' at (5,5) while reading (5,5) on the same edge -> old value 0, then 38 on the next read.
- Send 0x0C, then pulse reset_n low at sweep cycle 300 -> after release, busy=1 for a full 600 cycles, the cursor is (0,0), and all cells are 0.
